// File: rtl/shift_add_pkg.sv
// Shared types and sizing for the shift-and-add multiplier.
package shift_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEF = 4;

  // Counter must hold values 0..N, hence clog2(N+1).
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(N_DEF);

endpackage

// File: rtl/shift_add.sv
// Sequential unsigned multiplier: one shift-and-add iteration per clock,
// product registered only once all N iterations have completed.
module shift_add
  import shift_add_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  localparam int CW = cnt_width(N);

  state_t         r_state;
  state_t         w_state_next;
  logic [2*N-1:0] r_mcand;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] w_acc_sum;
  logic [N-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           w_load;
  logic           w_step;
  logic           w_last;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // DONE is held while start stays high so a level request never retriggers.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = start  ? CALC : IDLE;
      CALC:    w_state_next = w_last ? DONE : CALC;
      DONE:    w_state_next = start  ? DONE : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_load = (r_state == IDLE) && start;
    w_step = (r_state == CALC);
    w_last = w_step && (r_cnt == CW'(N - 1));
  end

  always_comb begin
    if (r_mplier[0]) begin
      w_acc_sum = r_acc + r_mcand;
    end else begin
      w_acc_sum = r_acc;
    end
  end

  // p is only written on the last iteration, so partial sums never escape.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      p        <= '0;
    end else if (w_load) begin
      r_mcand  <= {{N{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_acc    <= w_acc_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        p <= w_acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_shift_add.sv
// Directed bench for shift_add (N=4): latency, hold behaviour, reset abort.
module tb_shift_add;
  import shift_add_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic [3:0]   a;
  logic [3:0]   b;
  logic [W-1:0] p;

  int checks = 0;
  int errors = 0;

  shift_add #(.N(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .start (start),
    .a     (a),
    .b     (b),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] va [5] = '{4'd15, 4'd0, 4'd9, 4'd7, 4'd8};
  logic [3:0] vb [5] = '{4'd15, 4'd9, 4'd0, 4'd13, 4'd8};
  logic [7:0] vp [5] = '{8'd225, 8'd0, 8'd0, 8'd91, 8'd64};
  logic [7:0] prev;

  initial begin
    n_rst = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
    #3;
    chk("reset_p", p, 8'h00);
    chk("reset_state", 8'(dut.r_state), 8'(IDLE));
    #19;
    n_rst = 1'b1;

    // 1*3 with start held for 5 edges
    a = 4'd1; b = 4'd3; start = 1'b1;
    tick(1);
    chk("s1_calc", 8'(dut.r_state), 8'(CALC));
    tick(3);
    chk("s1_no_partial", p, 8'h00);
    tick(1);
    chk("s1_p", p, 8'h03);
    chk("s1_done", 8'(dut.r_state), 8'(DONE));
    start = 1'b0;
    tick(1);
    chk("s1_idle", 8'(dut.r_state), 8'(IDLE));

    // 5*12 after one idle cycle
    a = 4'd5; b = 4'd12;
    tick(1);
    chk("s2_idle_hold", 8'(dut.r_state), 8'(IDLE));
    chk("s2_idle_p", p, 8'h03);
    start = 1'b1;
    tick(4);
    chk("s2_p_held", p, 8'h03);
    tick(1);
    chk("s2_p", p, 8'h3C);
    start = 1'b0;
    tick(1);
    chk("s2_idle", 8'(dut.r_state), 8'(IDLE));

    // Operand table, one-cycle start pulse each
    prev = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      a = va[i]; b = vb[i]; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(3);
      chk("tbl_p_held", p, prev);
      tick(1);
      chk("tbl_p", p, vp[i]);
      chk("tbl_done", 8'(dut.r_state), 8'(DONE));
      tick(1);
      chk("tbl_idle", 8'(dut.r_state), 8'(IDLE));
      prev = vp[i];
    end

    // Operand and start changes during CALC are ignored
    a = 4'd6; b = 4'd11; start = 1'b1;
    tick(1);
    start = 1'b0; a = 4'd15; b = 4'd15;
    tick(1);
    a = 4'd3; b = 4'd2; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    chk("s4_p_held", p, 8'h40);
    tick(1);
    chk("s4_p", p, 8'h42);
    chk("s4_done", 8'(dut.r_state), 8'(DONE));
    tick(1);

    // Reset during the second CALC cycle aborts asynchronously
    a = 4'd13; b = 4'd14; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    #3;
    n_rst = 1'b0;
    #1;
    chk("s5_async_p", p, 8'h00);
    chk("s5_async_state", 8'(dut.r_state), 8'(IDLE));
    tick(1);
    n_rst = 1'b1;
    tick(3);
    chk("s5_stay_idle", 8'(dut.r_state), 8'(IDLE));
    chk("s5_p_zero", p, 8'h00);

    // start held 20 cycles: exactly one operation
    a = 4'd9; b = 4'd9; start = 1'b1;
    tick(5);
    chk("s6_p", p, 8'h51);
    a = 4'd1; b = 4'd1;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      chk("s6_p_stable", p, 8'h51);
      chk("s6_done_hold", 8'(dut.r_state), 8'(DONE));
    end
    start = 1'b0;
    tick(1);
    chk("s6_idle", 8'(dut.r_state), 8'(IDLE));
    chk("s6_p_final", p, 8'h51);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add.md
SHIFT_ADD -- requirements
Module: shift_add

Interface
REQ-001 The block SHALL have parameter N, default 4: operand width; product width is 2*N, and the verified configuration is N=4.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: level request to begin a multiplication.
REQ-005 The block SHALL have port a, input, N bits: unsigned multiplicand.
REQ-006 The block SHALL have port b, input, N bits: unsigned multiplier.
REQ-007 The block SHALL have port p, output, 2N bits: registered unsigned product of the most recent completed operation.

Function
REQ-008 The block SHALL implement FSM states IDLE, CALC and DONE, with state register, counter, operand registers and accumulator all clocked by clk.
REQ-009 In IDLE, start=1 at a rising edge SHALL cause these actions at that edge:
- capture a into the multiplicand register (zero-extended to 2N);
- capture b into the multiplier register;
- clear the accumulator and the iteration counter;
- move to CALC.
REQ-010 In IDLE with start=0, the state SHALL be held and p SHALL keep its value.
REQ-011 In CALC, each edge SHALL perform one iteration:
- if the multiplier LSB is 1, add the multiplicand to the accumulator, otherwise leave it;
- shift the multiplicand left by 1;
- shift the multiplier right by 1;
- increment the counter.
REQ-012 The block SHALL perform exactly N iterations; at the Nth CALC edge, p SHALL be loaded with the final sum and the state SHALL go to DONE.
REQ-013 Latency SHALL be fixed: with the capture edge as E0, p SHALL be valid immediately after edge E0+N (E0+4 for N=4), independent of operand values.
REQ-014 All arithmetic SHALL be unsigned, 2N bits wide, with no overflow possible; 15*15 = 225.
REQ-015 Changes to a, b and start during CALC SHALL be ignored.
REQ-016 The block SHALL stay in DONE while start=1, so a held start never retriggers; start=0 in DONE SHALL return to IDLE at the next edge.
REQ-017 A new operation SHALL be possible only from IDLE.
REQ-018 p SHALL change only at the final CALC edge (or at reset), and no intermediate sums SHALL be visible on p.

Reset
REQ-019 n_rst=0 SHALL immediately, without waiting for clk, force:
- state = IDLE;
- p = 0, counter = 0, accumulator = 0;
- operand registers = 0.
REQ-020 Reset asserted mid-CALC SHALL abort the operation and leave p = 0.
REQ-021 After reset release, the block SHALL require start=1 sampled in IDLE before any further activity.

Structure
REQ-022 The shared package SHALL hold:
- the FSM state enum (IDLE, CALC, DONE);
- the default width constant N = 4;
- the derived counter width, clog2(N+1).
REQ-023 The block SHALL be a single module with no sub-modules; the datapath (adder, shifters) and FSM SHALL be co-located in it, in separate sequential and combinational processes.

Verification
REQ-024 Scenario: n_rst low 20 ns, then released; a=1, b=3, start=1 held 5 cycles -> p=8'h03 after the 4th CALC edge, FSM in DONE while start=1, then IDLE.
REQ-025 Scenario: a=5, b=12, start low 1 cycle then high 5 cycles -> p holds 8'h03 until completion, then p=8'h3C (60).
REQ-026 Scenario: a=15, b=15 -> p=8'hE1 (225); a=0, b=9 -> p=8'h00; a=9, b=0 -> p=8'h00.
REQ-027 Scenario: start pulsed for 1 cycle, a and b changed during CALC -> the result uses the captured operands and latency is still 4 edges.
REQ-028 Scenario: n_rst asserted at the 2nd CALC edge -> p=0 and state=IDLE asynchronously; after release, no operation occurs until start=1.
REQ-029 Scenario: start held high 20 cycles -> exactly one operation is performed and p is stable after completion.
